// File: rtl/csc_pkg.sv
// Shared encodings for the CSCv2 clock-enable and reset sequencer.
package csc_pkg;

    typedef enum logic [1:0] {
        MODE_RUN  = 2'd0,
        MODE_HALT = 2'd1,
        MODE_STEP = 2'd2
    } mode_e;

    typedef enum logic {
        RST    = 1'b0,
        ACTIVE = 1'b1
    } seq_state_e;

endpackage

// File: rtl/csc_clkgen_if.sv
// Control/status bundle between the board top level and csc_clkgen.
interface csc_clkgen_if #(
    parameter int unsigned TAP_W = 5
) ();
    logic [TAP_W-1:0] tap_sel;
    logic [1:0]       mode;
    logic             step_req;
    logic             ext_reset_req;
    logic             cpu_ce;
    logic             cpu_clk_out;
    logic             uart_ce;
    logic             cpu_reset;
    logic             step_pending;

    modport master (
        output tap_sel, mode, step_req, ext_reset_req,
        input  cpu_ce, cpu_clk_out, uart_ce, cpu_reset, step_pending
    );

    modport slave (
        input  tap_sel, mode, step_req, ext_reset_req,
        output cpu_ce, cpu_clk_out, uart_ce, cpu_reset, step_pending
    );
endinterface

// File: rtl/csc_edge_det.sv
// Rising-edge detector: one history flop, loadable so a source switch
// can resynchronise it without reporting a false edge.
module csc_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    input  logic load,
    input  logic load_val,
    output logic rise_c
);
    logic hist_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 1'b0;
        end else if (load) begin
            hist_q <= load_val;
        end else begin
            hist_q <= d;
        end
    end

    assign rise_c = d & ~hist_q;
endmodule

// File: rtl/csc_clkgen.sv
// Divider-based CPU/UART clock-enable generator with HALT/STEP gating
// and a counted CPU reset sequence.
module csc_clkgen
    import csc_pkg::*;
#(
    parameter int unsigned DIV_WIDTH   = 24,
    parameter int unsigned TAP_W       = 5,
    parameter int unsigned RESET_TICKS = 4
) (
    input  logic        clk,
    input  logic        reset,
    csc_clkgen_if.slave bus
);
    localparam int unsigned       RST_CW  = $clog2(RESET_TICKS + 1);
    localparam logic [TAP_W-1:0]  TAP_MAX = TAP_W'(DIV_WIDTH - 2);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_nxt;
    logic [TAP_W-1:0]     tap_q;
    logic [TAP_W-1:0]     tap_eff;
    logic [TAP_W-1:0]     tap_up;
    logic                 tap_bit;
    logic                 uart_bit;
    logic                 tap_load;
    logic                 tap_rise_c;
    logic                 uart_rise_c;
    logic                 step_rise_c;
    logic                 ext_rise_c;
    logic                 tick_c;
    logic                 ce_c;
    seq_state_e           state_q;
    logic [RST_CW-1:0]    rst_cnt_q;
    logic                 cpu_ce_q;
    logic                 uart_ce_q;
    logic                 clk_out_q;
    logic                 cpu_reset_q;
    logic                 step_pending_q;

    // Edge detectors run on the next counter value so a registered tick
    // lines up with the cycle in which the tapped bit reads 1.
    assign tap_eff  = (bus.tap_sel > TAP_MAX) ? TAP_MAX : bus.tap_sel;
    assign tap_up   = tap_eff + TAP_W'(1);
    assign cnt_nxt  = cnt_q + DIV_WIDTH'(1);
    assign tap_bit  = cnt_nxt[tap_eff];
    assign uart_bit = cnt_nxt[tap_up];
    assign tap_load = (tap_eff != tap_q);
    assign tick_c   = tap_rise_c & ~tap_load;
    assign ce_c     = tick_c && (state_q == ACTIVE) &&
                      ((bus.mode == MODE_RUN) || ((bus.mode == MODE_STEP) && step_pending_q));

    csc_edge_det u_tap (
        .clk(clk), .reset(reset), .d(tap_bit),
        .load(tap_load), .load_val(tap_bit), .rise_c(tap_rise_c)
    );

    csc_edge_det u_uart (
        .clk(clk), .reset(reset), .d(uart_bit),
        .load(tap_load), .load_val(uart_bit), .rise_c(uart_rise_c)
    );

    csc_edge_det u_step (
        .clk(clk), .reset(reset), .d(bus.step_req),
        .load(1'b0), .load_val(1'b0), .rise_c(step_rise_c)
    );

    csc_edge_det u_ext (
        .clk(clk), .reset(reset), .d(bus.ext_reset_req),
        .load(1'b0), .load_val(1'b0), .rise_c(ext_rise_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q          <= '0;
            tap_q          <= tap_eff;
            state_q        <= RST;
            rst_cnt_q      <= '0;
            cpu_reset_q    <= 1'b1;
            cpu_ce_q       <= 1'b0;
            uart_ce_q      <= 1'b0;
            clk_out_q      <= 1'b0;
            step_pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_nxt;
            tap_q     <= tap_eff;
            clk_out_q <= tap_bit;
            uart_ce_q <= uart_rise_c & ~tap_load;
            cpu_ce_q  <= ce_c;

            // Reset sequencer: the tick that completes the count drops
            // cpu_reset but is not itself forwarded to cpu_ce.
            if (ext_rise_c) begin
                state_q     <= RST;
                cpu_reset_q <= 1'b1;
                rst_cnt_q   <= '0;
            end else if (tick_c && (state_q == RST)) begin
                rst_cnt_q <= rst_cnt_q + RST_CW'(1);
                if (rst_cnt_q == RST_CW'(RESET_TICKS - 1)) begin
                    state_q     <= ACTIVE;
                    cpu_reset_q <= 1'b0;
                end
            end

            // A new request wins over a coincident consume.
            if (bus.mode != MODE_STEP) begin
                step_pending_q <= 1'b0;
            end else if (step_rise_c) begin
                step_pending_q <= 1'b1;
            end else if (ce_c) begin
                step_pending_q <= 1'b0;
            end
        end
    end

    assign bus.cpu_ce       = cpu_ce_q;
    assign bus.cpu_clk_out  = clk_out_q;
    assign bus.uart_ce      = uart_ce_q;
    assign bus.cpu_reset    = cpu_reset_q;
    assign bus.step_pending = step_pending_q;
endmodule

// File: tb/tb_csc_clkgen.sv
// Bench for csc_clkgen: cycle-numbered expected cpu_ce pulses in a
// scoreboard queue, a vector table for mode runs, and corner sequences.
module tb_csc_clkgen;
    import csc_pkg::*;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    int   n_ce;
    int   n_uart;
    int   exp_q[$];

    typedef struct {
        logic [4:0] tap;
        logic [1:0] mode;
        int         len;
        int         exp_ce;
        int         exp_uart;
    } vec_t;

    vec_t vecs[4];

    csc_clkgen_if #(.TAP_W(5)) b ();
    csc_clkgen_if #(.TAP_W(3)) b2 ();

    csc_clkgen #(.DIV_WIDTH(24), .TAP_W(5), .RESET_TICKS(4)) u_dut (
        .clk(clk), .reset(reset), .bus(b)
    );

    csc_clkgen #(.DIV_WIDTH(6), .TAP_W(3), .RESET_TICKS(1)) u_dut2 (
        .clk(clk), .reset(reset), .bus(b2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bench-side cycle number: equals the divider value after reset.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step1();
        int e;
        @(negedge clk);
        if (b.cpu_ce === 1'b1) begin
            n_ce++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ce_unexpected: got pulse at cyc %0d want none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("ce_time", cyc, e);
            end
        end
        if (b.uart_ce === 1'b1) n_uart++;
        #1;
    endtask

    task automatic run_to(input int c);
        int guard;
        guard = 0;
        while (cyc != c && guard < 5000) begin
            step1();
            guard++;
        end
        if (cyc != c) begin
            total++;
            bad++;
            $display("FAIL run_to: got cyc %0d want %0d", cyc, c);
        end
    endtask

    initial begin
        int start;
        vecs[0] = '{tap: 5'd2, mode: 2'd1, len: 100, exp_ce: 0, exp_uart: 6};
        vecs[1] = '{tap: 5'd2, mode: 2'd0, len: 64,  exp_ce: 8, exp_uart: 4};
        vecs[2] = '{tap: 5'd2, mode: 2'd3, len: 40,  exp_ce: 0, exp_uart: 3};
        vecs[3] = '{tap: 5'd2, mode: 2'd0, len: 32,  exp_ce: 4, exp_uart: 2};
        total = 0; bad = 0; n_ce = 0; n_uart = 0;

        reset = 1'b1;
        b.tap_sel = 5'd2; b.mode = MODE_RUN; b.step_req = 1'b0; b.ext_reset_req = 1'b0;
        b2.tap_sel = 3'd7; b2.mode = MODE_RUN; b2.step_req = 1'b0; b2.ext_reset_req = 1'b0;

        // Reset state
        repeat (3) step1();
        chk("rst_cpu_reset", b.cpu_reset, 1);
        chk("rst_cpu_ce", b.cpu_ce, 0);
        chk("rst_uart_ce", b.uart_ce, 0);
        chk("rst_clk_out", b.cpu_clk_out, 0);
        chk("rst_step_pending", b.step_pending, 0);

        // Reset release, tap 2, RUN
        reset = 1'b0;
        exp_q.push_back(36); exp_q.push_back(44); exp_q.push_back(52); exp_q.push_back(60);
        run_to(3);  chk("clk_out_c3", b.cpu_clk_out, 0);
        run_to(4);  chk("clk_out_c4", b.cpu_clk_out, 1);
        run_to(15); chk("clamp_clk_out_c15", b2.cpu_clk_out, 0);
        run_to(16); chk("clamp_clk_out_c16", b2.cpu_clk_out, 1);
        run_to(27); chk("seq_reset_c27", b.cpu_reset, 1);
        run_to(28); chk("seq_reset_c28", b.cpu_reset, 0);
        run_to(31); chk("clamp_clk_out_c31", b2.cpu_clk_out, 1);
        chk("clamp_uart_c31", b2.uart_ce, 0);
        run_to(32); chk("clamp_clk_out_c32", b2.cpu_clk_out, 0);
        chk("clamp_uart_c32", b2.uart_ce, 1);
        run_to(62); chk("ce_missing_p1", exp_q.size(), 0);

        // Mode vectors
        for (int i = 0; i < 4; i++) begin
            start = cyc;
            b.tap_sel = vecs[i].tap;
            b.mode    = vecs[i].mode;
            for (int c = start + 1; c <= start + vecs[i].len; c++)
                if (vecs[i].mode == MODE_RUN && (c % 8) == 4) exp_q.push_back(c);
            n_ce = 0; n_uart = 0;
            repeat (vecs[i].len) step1();
            chk("vec_ce_cnt", n_ce, vecs[i].exp_ce);
            chk("vec_uart_cnt", n_uart, vecs[i].exp_uart);
        end

        // STEP mode
        run_to(298); b.mode = MODE_STEP;
        chk("step_idle", b.step_pending, 0);
        run_to(300); b.step_req = 1'b1; exp_q.push_back(308);
        run_to(301); chk("step_armed", b.step_pending, 1);
        run_to(302); b.step_req = 1'b0;
        run_to(304); b.step_req = 1'b1;
        run_to(306); b.step_req = 1'b0;
        run_to(308); chk("step_consumed", b.step_pending, 0);
        run_to(350); b.step_req = 1'b1; exp_q.push_back(356);
        run_to(352); b.step_req = 1'b0;
        run_to(375); b.step_req = 1'b1;
        run_to(377); b.step_req = 1'b0;
        run_to(379); b.step_req = 1'b1; exp_q.push_back(380); exp_q.push_back(388);
        run_to(380); chk("step_coincident_kept", b.step_pending, 1);
        run_to(381); b.step_req = 1'b0;
        run_to(388); chk("step_second_consumed", b.step_pending, 0);

        // Leaving STEP drops a pending step
        run_to(400); b.step_req = 1'b1;
        run_to(401); chk("step_leave_armed", b.step_pending, 1);
        run_to(402); b.step_req = 1'b0; b.mode = MODE_HALT;
        run_to(403); chk("step_leave_cleared", b.step_pending, 0);

        // External reset, restarted mid-sequence
        run_to(410); b.ext_reset_req = 1'b1; b.mode = MODE_RUN;
        run_to(411); chk("ext_reset_enter", b.cpu_reset, 1);
        run_to(412); b.ext_reset_req = 1'b0;
        run_to(425); b.ext_reset_req = 1'b1;
        run_to(427); b.ext_reset_req = 1'b0;
        run_to(451); chk("ext_reset_c451", b.cpu_reset, 1);
        run_to(452); chk("ext_reset_c452", b.cpu_reset, 0);
        exp_q.push_back(460); exp_q.push_back(468);

        // Tap change 2 -> 5 with no tick in the change cycle
        run_to(470); exp_q.push_back(476); n_uart = 0;
        run_to(480); b.tap_sel = 5'd5; exp_q.push_back(544); exp_q.push_back(608);
        run_to(500); chk("tap5_clk_out_c500", b.cpu_clk_out, 1);
        run_to(520); chk("tap5_clk_out_c520", b.cpu_clk_out, 0);
        run_to(540); chk("tap_change_uart_cnt", n_uart, 1);

        // Out-of-range tap clamps to the top usable bit
        run_to(610); b.tap_sel = 5'd31; n_uart = 0; n_ce = 0;
        run_to(640); chk("tap31_clk_out", b.cpu_clk_out, 0);
        chk("tap31_uart_cnt", n_uart, 0);
        chk("ce_missing_p7", exp_q.size(), 0);

        // Reset during STEP with a step pending
        b.tap_sel = 5'd2; b.mode = MODE_STEP;
        run_to(645); b.step_req = 1'b1;
        run_to(646); chk("rst_step_armed", b.step_pending, 1);
        reset = 1'b1; b.step_req = 1'b0;
        step1();
        chk("rst2_step_pending", b.step_pending, 0);
        chk("rst2_cpu_reset", b.cpu_reset, 1);
        chk("rst2_clk_out", b.cpu_clk_out, 0);
        reset = 1'b0; b.mode = MODE_RUN;
        exp_q.push_back(36); exp_q.push_back(44);
        run_to(27); chk("rst2_seq_c27", b.cpu_reset, 1);
        run_to(28); chk("rst2_seq_c28", b.cpu_reset, 0);
        run_to(46); chk("ce_missing_end", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
